// File: rtl/wb_arbiter_pkg.sv
// Shared CPU package: writeback datapath widths and the arbitration priority state.
package wb_arbiter_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    // Names the requester that wins when both ask in the same cycle.
    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_MEM = 1'b1
    } pri_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Register pending-write scoreboard: issue sets a bit, writeback clears it, two read ports check it.
module wb_scoreboard
    import wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en_i,
    input  logic [ADDR_W-1:0]    set_addr_i,
    input  logic                 clr_en_i,
    input  logic [ADDR_W-1:0]    clr_addr_i,
    input  logic [ADDR_W-1:0]    chk_addr1_i,
    input  logic [ADDR_W-1:0]    chk_addr2_i,
    output logic                 hit_o,
    output logic [2**ADDR_W-1:0] busy_mask_o
);

    logic [2**ADDR_W-1:0] busy_q;
    logic [2**ADDR_W-1:0] busy_d;

    // Set is applied after clear so a new producer issued on the retiring edge stays pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hit_o       = busy_q[chk_addr1_i] | busy_q[chk_addr2_i];
    assign busy_mask_o = busy_q;

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester writeback arbiter (ALU vs load unit) with alternating priority,
// a registered register-file write port and an issue-hazard scoreboard.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_addr,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 issue_en,
    input  logic [ADDR_W-1:0]    issue_addr,
    input  logic [ADDR_W-1:0]    chk_addr1,
    input  logic [ADDR_W-1:0]    chk_addr2,
    output logic                 stall,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_w_addr,
    output logic [DATA_W-1:0]    rf_w_data,
    output logic [2**ADDR_W-1:0] busy_mask,
    output pri_state_t           pri_state_dbg
);

    // Handshake: a requester transfers on a cycle where its valid and ready are both high.
    // Ready never rises without valid, and both are held low while rst is high.
    pri_state_t          pri_q, pri_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]   rf_data_q, rf_data_d;

    assign alu_ready = !rst && alu_valid && (!mem_valid || pri_q == PRI_ALU);
    assign mem_ready = !rst && mem_valid && (!alu_valid || pri_q == PRI_MEM);

    always_comb begin
        pri_d = pri_q;
        if (alu_valid && mem_valid) begin
            pri_d = (pri_q == PRI_ALU) ? PRI_MEM : PRI_ALU;
        end
    end

    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (alu_ready) begin
            rf_we_d   = 1'b1;
            rf_addr_d = alu_addr;
            rf_data_d = alu_data;
        end else if (mem_ready) begin
            rf_we_d   = 1'b1;
            rf_addr_d = mem_addr;
            rf_data_d = mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q     <= PRI_ALU;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            pri_q     <= pri_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_we         = rf_we_q;
    assign rf_w_addr     = rf_addr_q;
    assign rf_w_data     = rf_data_q;
    assign pri_state_dbg = pri_q;

    // Clearing on the registered write keeps the scoreboard in step with the register file commit.
    wb_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (issue_en),
        .set_addr_i (issue_addr),
        .clr_en_i   (rf_we_q),
        .clr_addr_i (rf_addr_q),
        .chk_addr1_i(chk_addr1),
        .chk_addr2_i(chk_addr2),
        .hit_o      (stall),
        .busy_mask_o(busy_mask)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: arbitration order, write latency, scoreboard set/clear and reset behaviour.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          alu_valid, alu_ready, mem_valid, mem_ready;
    logic [AW-1:0] alu_addr, mem_addr, issue_addr, chk_addr1, chk_addr2;
    logic [DW-1:0] alu_data, mem_data;
    logic          issue_en, stall, rf_we;
    logic [AW-1:0] rf_w_addr;
    logic [DW-1:0] rf_w_data;
    logic [15:0]   busy_mask;
    pri_state_t    pri_state_dbg;

    int n_cmp = 0;
    int n_mis = 0;
    logic [AW+DW-1:0] exp_q[$];

    wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .stall(stall),
        .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
        .busy_mask(busy_mask), .pri_state_dbg(pri_state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_addr = '0; alu_data = '0;
        mem_valid = 0; mem_addr = '0; mem_data = '0;
        issue_en = 0; issue_addr = '0;
    endtask

    // Scoreboard: every rf_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rf_unexpected_write", 32'(rf_w_addr), 32'hFFFF_FFFF);
            end else begin
                check("rf_write", 32'({rf_w_addr, rf_w_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1; chk_addr1 = '0; chk_addr2 = '0;
        idle_inputs();
        tick(); tick();
        alu_valid = 1; #1;
        check("rst_alu_ready", 32'(alu_ready), 0);
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_rf_addr", 32'(rf_w_addr), 0);
        check("rst_rf_data", 32'(rf_w_data), 0);
        check("rst_busy", 32'(busy_mask), 0);
        check("rst_pri", 32'(pri_state_dbg), 32'(PRI_ALU));
        alu_valid = 0;
        tick();
        rst = 0;

        // ALU alone
        alu_valid = 1; alu_addr = 4'd3; alu_data = 16'h1234; #1;
        check("alu_only_ready", 32'(alu_ready), 1);
        check("alu_only_mem_ready", 32'(mem_ready), 0);
        exp_q.push_back({4'd3, 16'h1234});
        tick(); idle_inputs();
        check("alu_only_we", 32'(rf_we), 1);
        check("alu_only_addr", 32'(rf_w_addr), 3);
        check("alu_only_data", 32'(rf_w_data), 16'h1234);
        check("alu_only_pri", 32'(pri_state_dbg), 32'(PRI_ALU));
        tick();
        check("idle_we", 32'(rf_we), 0);
        check("idle_hold_addr", 32'(rf_w_addr), 3);
        check("idle_hold_data", 32'(rf_w_data), 16'h1234);

        // MEM alone
        mem_valid = 1; mem_addr = 4'd6; mem_data = 16'hBEEF; #1;
        check("mem_only_ready", 32'(mem_ready), 1);
        check("mem_only_alu_ready", 32'(alu_ready), 0);
        exp_q.push_back({4'd6, 16'hBEEF});
        tick(); idle_inputs();
        check("mem_only_pri", 32'(pri_state_dbg), 32'(PRI_ALU));

        // Conflicts alternate ALU, MEM, ALU, MEM
        alu_valid = 1; alu_addr = 4'd1; alu_data = 16'h1111;
        mem_valid = 1; mem_addr = 4'd2; mem_data = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("alt_alu_ready", 32'(alu_ready), (i % 2 == 0) ? 1 : 0);
            check("alt_mem_ready", 32'(mem_ready), (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 0) exp_q.push_back({4'd1, 16'h1111});
            else            exp_q.push_back({4'd2, 16'h2222});
            tick();
            check("alt_rf_addr", 32'(rf_w_addr), (i % 2 == 0) ? 1 : 2);
        end
        idle_inputs();
        check("alt_pri_end", 32'(pri_state_dbg), 32'(PRI_ALU));

        // Same destination from both: grant order preserved, last write wins
        alu_valid = 1; alu_addr = 4'd4; alu_data = 16'hAAAA;
        mem_valid = 1; mem_addr = 4'd4; mem_data = 16'hBBBB;
        exp_q.push_back({4'd4, 16'hAAAA});
        exp_q.push_back({4'd4, 16'hBBBB});
        tick(); tick(); idle_inputs();
        check("same_dst_last", 32'(rf_w_data), 16'hBBBB);
        tick();
        check("hold_pri", 32'(pri_state_dbg), 32'(PRI_ALU));
        check("hold_we", 32'(rf_we), 0);

        // Hazard on register 5 lasts until its write commits
        chk_addr1 = 4'd5; chk_addr2 = 4'd0;
        issue_en = 1; issue_addr = 4'd5; #1;
        check("haz_pre_stall", 32'(stall), 0);
        tick(); idle_inputs();
        check("haz_busy_set", 32'(busy_mask), 16'h0020);
        check("haz_stall", 32'(stall), 1);
        alu_valid = 1; alu_addr = 4'd5; alu_data = 16'h5555;
        exp_q.push_back({4'd5, 16'h5555});
        tick(); idle_inputs();
        check("haz_we_cycle_stall", 32'(stall), 1);
        check("haz_we_cycle_busy", 32'(busy_mask), 16'h0020);
        tick();
        check("haz_cleared_busy", 32'(busy_mask), 0);
        check("haz_cleared_stall", 32'(stall), 0);

        // Set wins over simultaneous clear of register 7; checked on read port 2
        chk_addr1 = 4'd0; chk_addr2 = 4'd7;
        issue_en = 1; issue_addr = 4'd7;
        tick(); idle_inputs();
        check("r7_busy", 32'(busy_mask), 16'h0080);
        alu_valid = 1; alu_addr = 4'd7; alu_data = 16'h7777;
        exp_q.push_back({4'd7, 16'h7777});
        tick(); idle_inputs();
        issue_en = 1; issue_addr = 4'd7;
        tick(); idle_inputs();
        check("set_wins_busy", 32'(busy_mask), 16'h0080);
        check("set_wins_stall2", 32'(stall), 1);
        issue_en = 1; issue_addr = 4'd7;
        tick(); idle_inputs();
        check("reissue_busy", 32'(busy_mask), 16'h0080);

        // Reset during a MEM grant after priority has moved to MEM
        alu_valid = 1; alu_addr = 4'd10; alu_data = 16'hA0A0;
        mem_valid = 1; mem_addr = 4'd9;  mem_data = 16'h9999;
        issue_en = 1; issue_addr = 4'd2;
        exp_q.push_back({4'd10, 16'hA0A0});
        tick();
        alu_valid = 0; issue_en = 0; #1;
        check("pre_rst_pri", 32'(pri_state_dbg), 32'(PRI_MEM));
        check("pre_rst_mem_ready", 32'(mem_ready), 1);
        rst = 1; #1;
        check("rst_mem_ready", 32'(mem_ready), 0);
        tick();
        check("rst_mid_we", 32'(rf_we), 0);
        check("rst_mid_addr", 32'(rf_w_addr), 0);
        check("rst_mid_data", 32'(rf_w_data), 0);
        check("rst_mid_busy", 32'(busy_mask), 0);
        check("rst_mid_stall", 32'(stall), 0);
        tick();
        check("rst_hold_we", 32'(rf_we), 0);
        rst = 0;
        alu_valid = 1; alu_addr = 4'd11; alu_data = 16'hC0DE; #1;
        check("post_rst_alu_ready", 32'(alu_ready), 1);
        check("post_rst_mem_ready", 32'(mem_ready), 0);
        exp_q.push_back({4'd11, 16'hC0DE});
        tick(); idle_inputs();
        check("post_rst_addr", 32'(rf_w_addr), 11);
        tick(); tick();

        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
